// File: rtl/pipeline_hazard_ctrl_pkg.sv
// otter_pipe_pkg: shared FSM state, forwarding-select encodings and the forwarding priority rule.
package otter_pipe_pkg;
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} ctrl_state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  localparam int REG_W = 5;
  function automatic fwd_sel_t fwd_sel(logic [REG_W-1:0] rs, logic [REG_W-1:0] rd_m, logic wr_m,
                                       logic [REG_W-1:0] rd_w, logic wr_w);
    return (wr_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
           (wr_w && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: stage register/hazard info in, stall/flush/forward controls and status out.
interface pipeline_hazard_ctrl_if #(parameter int COUNT_W = 32);
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic rs1_used_D, rs2_used_D, mem_read_E, reg_write_E, reg_write_M, reg_write_W;
  logic branch_taken_E, dmem_busy_M;
  logic stall_F, stall_D, stall_EM, flush_D, flush_E;
  otter_pipe_pkg::fwd_sel_t fwdA_E, fwdB_E;
  logic [COUNT_W-1:0] stall_count, flush_count;
  logic mem_timeout;
  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, rs1_used_D, rs2_used_D, mem_read_E,
           reg_write_E, reg_write_M, reg_write_W, branch_taken_E, dmem_busy_M,
    input  stall_F, stall_D, stall_EM, flush_D, flush_E, fwdA_E, fwdB_E, stall_count, flush_count,
           mem_timeout
  );
  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, rs1_used_D, rs2_used_D, mem_read_E,
           reg_write_E, reg_write_M, reg_write_W, branch_taken_E, dmem_busy_M,
    output stall_F, stall_D, stall_EM, flush_D, flush_E, fwdA_E, fwdB_E, stall_count, flush_count,
           mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward.sv
// forward_unit: EX operand source selects; the M stage is younger so it wins over W.
module forward_unit
  import otter_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs1_E,
  input  logic [REG_W-1:0] rs2_E,
  input  logic [REG_W-1:0] rd_M,
  input  logic [REG_W-1:0] rd_W,
  input  logic             reg_write_M,
  input  logic             reg_write_W,
  output fwd_sel_t         fwdA_E,
  output fwd_sel_t         fwdB_E
);
  assign fwdA_E = fwd_sel(rs1_E, rd_M, reg_write_M, rd_W, reg_write_W);
  assign fwdB_E = fwd_sel(rs2_E, rd_M, reg_write_M, rd_W, reg_write_W);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Otter pipeline stall/flush sequencing, post-reset clear, perf counters, mem timeout.
module pipeline_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int RESET_BUBBLES = 3,
  parameter int MAX_WAIT      = 16,
  parameter int COUNT_W       = 32
) (
  input logic CLK,
  input logic RST_N,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int BW = $clog2(RESET_BUBBLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  ctrl_state_t state;
  logic [BW-1:0] bubble_cnt;
  logic [WW-1:0] wait_cnt;
  logic [COUNT_W-1:0] stall_cnt, flush_cnt;
  logic timeout, init, active, load_use, freeze, branch, lu_stall, stall_f;
  logic [WW-1:0] wait_inc;
  assign init = state == INIT;
  assign active = !init && !hz.dmem_busy_M;
  assign freeze = !init && hz.dmem_busy_M;
  assign load_use = hz.mem_read_E && hz.reg_write_E && hz.rd_E != '0 &&
                    ((hz.rs1_used_D && hz.rs1_D == hz.rd_E) || (hz.rs2_used_D && hz.rs2_D == hz.rd_E));
  // A taken branch squashes the Decode instr, so its load-use stall is moot.
  assign branch = active && hz.branch_taken_E;
  assign lu_stall = active && !hz.branch_taken_E && load_use;
  assign stall_f = init || freeze || lu_stall;
  assign hz.stall_F = stall_f;
  assign hz.stall_D = freeze || lu_stall;
  assign hz.stall_EM = freeze;
  assign hz.flush_D = init || branch;
  assign hz.flush_E = init || branch || lu_stall;
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
  assign hz.mem_timeout = timeout;
  assign wait_inc = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= INIT;
      bubble_cnt <= '0;
      wait_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          bubble_cnt <= bubble_cnt + 1'b1;
          if (bubble_cnt == BW'(RESET_BUBBLES - 1)) state <= RUN;
        end
        RUN: if (hz.dmem_busy_M) begin
          state <= MEM_WAIT;
          wait_cnt <= WW'(1);
          if (MAX_WAIT == 1) timeout <= 1'b1;
        end
        default: if (hz.dmem_busy_M) begin
          wait_cnt <= wait_inc;
          if (wait_inc == WW'(MAX_WAIT)) timeout <= 1'b1;
        end else state <= RUN;
      endcase
      if (!init && stall_f && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (branch && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  forward_unit u_fwd (
    .rs1_E(hz.rs1_E), .rs2_E(hz.rs2_E), .rd_M(hz.rd_M), .rd_W(hz.rd_W),
    .reg_write_M(hz.reg_write_M), .reg_write_W(hz.reg_write_W),
    .fwdA_E(hz.fwdA_E), .fwdB_E(hz.fwdB_E)
  );
endmodule
